basys3_debounce: RTL and testbench
==================================

BASYS3_DEBOUNCE -- requirements
Module: basys3_debounce

Interface
REQ-001 Parameter NUM_CH, default 5, number of independent input channels (Basys3 push-buttons); legal range 1..32.
REQ-002 Parameter SYNC_STAGES, default 2, synchroniser flop depth per channel; legal range 2..4.
REQ-003 Parameter DEBOUNCE_CYCLES, default 1000000, consecutive stable cycles needed to accept a new level (10 ms at 100 MHz); legal range 1..2^24.
REQ-004 Parameter INIT_LEVEL, default 1'b0, reset value of every synchroniser flop and debounced level.
REQ-005 clk_ext  input  1  single clock, driven from the global buffer; all logic on its rising edge.
REQ-006 rst  input  1  reset: synchronous, active-high.
REQ-007 btn_in  input  NUM_CH  raw asynchronous pad-side inputs, one bit per channel.
REQ-008 btn_level  output  NUM_CH  registered debounced level per channel.
REQ-009 btn_rise  output  NUM_CH  one-cycle pulse when btn_level goes 0->1.
REQ-010 btn_fall  output  NUM_CH  one-cycle pulse when btn_level goes 1->0.
REQ-011 btn_busy  output  NUM_CH  high while the channel's stability counter is non-zero.

Function
REQ-012 Each channel SHALL pass btn_in[i] through a SYNC_STAGES-deep flop chain before any other use; no raw input reaches other logic.
REQ-013 Each channel SHALL hold a counter of width clog2(DEBOUNCE_CYCLES+1) bits.
REQ-014 Synchronised value == btn_level[i]: counter SHALL clear to 0 on that edge.
REQ-015 Synchronised value != btn_level[i] and counter < DEBOUNCE_CYCLES-1: counter SHALL increment by 1.
REQ-016 Synchronised value != btn_level[i] and counter == DEBOUNCE_CYCLES-1: btn_level[i] SHALL take the synchronised value and counter SHALL clear, on the same edge.
REQ-017 Latency: a pad change held stable SHALL appear on btn_level exactly SYNC_STAGES + DEBOUNCE_CYCLES rising edges after the first edge that samples it.
REQ-018 A glitch shorter than DEBOUNCE_CYCLES synchronised cycles SHALL clear the counter and leave btn_level unchanged; the counter never wraps.
REQ-019 DEBOUNCE_CYCLES == 1: btn_level SHALL follow the synchroniser output with one extra register stage.
REQ-020 btn_rise/btn_fall SHALL assert in the same cycle btn_level first shows the new value, for exactly one cycle, and never both for the same channel.
REQ-021 Channels SHALL be fully independent; simultaneous transitions on any subset SHALL each complete with identical latency.
REQ-022 btn_busy[i] SHALL be a registered copy of (counter != 0).

Reset
REQ-023 While rst is high, synchroniser flops and btn_level SHALL load INIT_LEVEL; counters, btn_rise, btn_fall, btn_busy SHALL load 0.
REQ-024 Reset asserted mid-count SHALL abort the count; no edge pulse SHALL be generated on the cycle rst deasserts or on the cycle after.
REQ-025 After rst deasserts with btn_in == INIT_LEVEL, all outputs SHALL remain at reset values.

Configuration
REQ-026 Macro BASYS3_DEBOUNCE_EDGE_EN defined: edge-detect registers are built and btn_rise/btn_fall behave per REQ-020.
REQ-027 Macro BASYS3_DEBOUNCE_EDGE_EN undefined: no edge-detect registers are built; btn_rise and btn_fall SHALL be tied to constant 0; all other behaviour unchanged.

Verification (NUM_CH=5, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, INIT_LEVEL=0, macro defined)
REQ-028 Reset then btn_in=5'b00000 for 20 cycles -> btn_level=0, btn_rise=btn_fall=btn_busy=0 every cycle.
REQ-029 btn_in[0] 0->1 held -> btn_level[0]=1 on edge 6 after first sampling edge; btn_rise[0]=1 for exactly that cycle.
REQ-030 btn_in[2] high for 3 cycles then low -> btn_level[2] stays 0, btn_busy[2] high then 0, no pulses.
REQ-031 btn_in=5'b11111 simultaneously, held, then 5'b00000 after 20 cycles -> all five levels rise on the same edge, all five btn_fall pulse on the same later edge.
REQ-032 btn_in[1] held high, rst asserted on 3rd counting cycle for 2 cycles -> btn_level[1]=0 through reset, then rises 6 edges after rst deasserts, single btn_rise[1].
REQ-033 Rebuild without BASYS3_DEBOUNCE_EDGE_EN, repeat REQ-029 -> btn_level timing identical, btn_rise/btn_fall constantly 0.

Source files
------------

// File: rtl/basys3_debounce.sv
// basys3_debounce: per-channel synchroniser, stability-counter debouncer and
// edge detector for the Basys3 push-buttons.
// Optional feature macro: BASYS3_DEBOUNCE_EDGE_EN builds the btn_rise/btn_fall
// edge-detect registers; when undefined, both outputs are tied to 0.
module basys3_debounce #(
    parameter int unsigned NUM_CH          = 5,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter logic        INIT_LEVEL      = 1'b0
) (
    input  logic              clk_ext,
    input  logic              rst,
    input  logic [NUM_CH-1:0] btn_in,
    output logic [NUM_CH-1:0] btn_level,
    output logic [NUM_CH-1:0] btn_rise,
    output logic [NUM_CH-1:0] btn_fall,
    output logic [NUM_CH-1:0] btn_busy
);

    localparam int unsigned    CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q [NUM_CH];
    logic [CW-1:0]          cnt_q  [NUM_CH];
    logic [CW-1:0]          cnt_d  [NUM_CH];
    logic [NUM_CH-1:0]      sync_out;
    logic [NUM_CH-1:0]      level_q;
    logic [NUM_CH-1:0]      level_d;
    logic [NUM_CH-1:0]      busy_q;

    // Synchroniser chains: raw pad inputs are only ever seen by these flops.
    always_ff @(posedge clk_ext) begin
        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            if (rst) begin
                sync_q[ch] <= {SYNC_STAGES{INIT_LEVEL}};
            end else begin
                sync_q[ch] <= {sync_q[ch][SYNC_STAGES-2:0], btn_in[ch]};
            end
        end
    end

    // Stability counter next-state: clear when settled, accept on the last count.
    always_comb begin
        level_d = level_q;
        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            sync_out[ch] = sync_q[ch][SYNC_STAGES-1];
            cnt_d[ch]    = '0;
            if (sync_out[ch] != level_q[ch]) begin
                if (cnt_q[ch] == LAST) begin
                    level_d[ch] = sync_out[ch];
                end else begin
                    cnt_d[ch] = cnt_q[ch] + CW'(1);
                end
            end
        end
    end

    // Counter, debounced level and busy-flag registers.
    always_ff @(posedge clk_ext) begin
        if (rst) begin
            level_q <= {NUM_CH{INIT_LEVEL}};
            busy_q  <= '0;
            for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                cnt_q[ch] <= '0;
            end
        end else begin
            level_q <= level_d;
            for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                cnt_q[ch]  <= cnt_d[ch];
                busy_q[ch] <= (cnt_q[ch] != '0);
            end
        end
    end

    assign btn_level = level_q;
    assign btn_busy  = busy_q;

`ifdef BASYS3_DEBOUNCE_EDGE_EN
    logic [NUM_CH-1:0] rise_q;
    logic [NUM_CH-1:0] fall_q;

    // Edge pulses computed from the level next-state so they line up with btn_level.
    always_ff @(posedge clk_ext) begin
        if (rst) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= level_d & ~level_q;
            fall_q <= ~level_d & level_q;
        end
    end

    assign btn_rise = rise_q;
    assign btn_fall = fall_q;
`else
    assign btn_rise = '0;
    assign btn_fall = '0;
`endif

endmodule

// File: tb/tb_basys3_debounce.sv
// Scoreboard bench for basys3_debounce (NUM_CH=5, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4, INIT_LEVEL=0). Expected edge pulses depend on
// BASYS3_DEBOUNCE_EDGE_EN being defined for the build.
module tb_basys3_debounce;

    logic       clk_ext = 1'b0;
    logic       rst     = 1'b1;
    logic [4:0] btn_in  = '0;
    logic [4:0] btn_level;
    logic [4:0] btn_rise;
    logic [4:0] btn_fall;
    logic [4:0] btn_busy;

    basys3_debounce #(
        .NUM_CH         (5),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .INIT_LEVEL     (1'b0)
    ) dut (
        .clk_ext  (clk_ext),
        .rst      (rst),
        .btn_in   (btn_in),
        .btn_level(btn_level),
        .btn_rise (btn_rise),
        .btn_fall (btn_fall),
        .btn_busy (btn_busy)
    );

    always #5 clk_ext = ~clk_ext;

    typedef struct {
        int         cyc;
        logic [4:0] level;
        logic [4:0] busy;
        logic [4:0] rise;
        logic [4:0] fall;
    } exp_t;

    exp_t sb[$];

    int   cyc     = 0;
    int   checks  = 0;
    int   errors  = 0;
    bit   mon_en  = 1'b0;
    bit   done    = 1'b0;

    logic [4:0] exp_level = '0;
    logic [4:0] exp_busy  = '0;
    logic [4:0] exp_rise;
    logic [4:0] exp_fall;

    always @(posedge clk_ext) cyc <= cyc + 1;

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, req);
        end
    endtask

    task automatic push(input int c, input logic [4:0] lv, input logic [4:0] bz,
                        input logic [4:0] r, input logic [4:0] f);
        exp_t e;
        e.cyc = c; e.level = lv; e.busy = bz; e.rise = r; e.fall = f;
        sb.push_back(e);
    endtask

    // Change issued after edge k: busy from k+4, level at k+6, busy clears at k+7.
    task automatic push_change(input int k, input logic [4:0] old_lv,
                               input logic [4:0] new_lv, input logic [4:0] mask);
        push(k + 4, old_lv, mask, '0, '0);
        push(k + 6, new_lv, mask, new_lv & ~old_lv, old_lv & ~new_lv);
        push(k + 7, new_lv, '0, '0, '0);
    endtask

    // Glitch too short to be accepted: busy window only, level untouched.
    task automatic push_glitch(input int k, input logic [4:0] lv, input logic [4:0] mask);
        push(k + 4, lv, mask, '0, '0);
        push(k + 7, lv, '0, '0, '0);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_ext);
    endtask

    // Monitor: every cycle compare all outputs against the scoreboard state.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_ext);
            if (mon_en) begin
                while (sb.size() > 0 && sb[0].cyc < cyc) begin
                    e = sb.pop_front();
                    check("stale_event", 5'd0, 5'd1);
                end
                exp_rise = '0;
                exp_fall = '0;
                if (sb.size() > 0 && sb[0].cyc == cyc) begin
                    e = sb.pop_front();
                    exp_level = e.level;
                    exp_busy  = e.busy;
`ifdef BASYS3_DEBOUNCE_EDGE_EN
                    exp_rise  = e.rise;
                    exp_fall  = e.fall;
`endif
                end
                check("level", btn_level, exp_level);
                check("busy",  btn_busy,  exp_busy);
                check("rise",  btn_rise,  exp_rise);
                check("fall",  btn_fall,  exp_fall);
            end
        end
    end

    // Stimulus.
    initial begin
        int k;
        rst    = 1'b1;
        btn_in = '0;
        step(3);
        mon_en = 1'b1;
        step(2);
        rst = 1'b0;
        // Idle after reset: everything stays at reset values.
        step(20);

        // Single channel rise, then release.
        k = cyc; btn_in = 5'b00001; push_change(k, 5'b00000, 5'b00001, 5'b00001);
        step(12);
        k = cyc; btn_in = 5'b00000; push_change(k, 5'b00001, 5'b00000, 5'b00001);
        step(12);

        // Three-cycle glitch on channel 2.
        k = cyc; btn_in = 5'b00100; push_glitch(k, 5'b00000, 5'b00100);
        step(3);
        btn_in = 5'b00000;
        step(12);

        // All channels together, then all released.
        k = cyc; btn_in = 5'b11111; push_change(k, 5'b00000, 5'b11111, 5'b11111);
        step(20);
        k = cyc; btn_in = 5'b00000; push_change(k, 5'b11111, 5'b00000, 5'b11111);
        step(12);

        // Reset on the third counting edge of channel 1, held for two edges.
        k = cyc; btn_in = 5'b00010;
        push(k + 4, 5'b00000, 5'b00010, '0, '0);
        step(4);
        rst = 1'b1;
        push(cyc + 1, 5'b00000, 5'b00000, '0, '0);
        step(2);
        rst = 1'b0;
        k = cyc; push_change(k, 5'b00000, 5'b00010, 5'b00010);
        step(12);

        btn_in = 5'b00000;
        mon_en = 1'b0;
        step(1);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain actual=%0d required=0 pending events", sb.size());
        end
        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog bounding the whole run.
    initial begin
        #100000;
        if (!done) begin
            errors++;
            $display("FAIL watchdog actual=timeout required=finished");
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

endmodule
